// File: rtl/car_sig_pkg.sv
// ----------------------------------------------------------------------------
// car_sig_pkg
// Shared definitions for the car command UART transmitter:
//   - bit positions of each command inside the transmitted byte
//   - FSM state encoding
//   - default UART bit rate
//   - pack_cmd(): snapshot sanitiser + byte packer
// Optional feature macro used by the users of this package: TX_PARITY_EN.
// ----------------------------------------------------------------------------
package car_sig_pkg;

    localparam int SIG_FWD     = 0;
    localparam int SIG_BWD     = 1;
    localparam int SIG_LEFT    = 2;
    localparam int SIG_RIGHT   = 3;
    localparam int SIG_PLACE   = 4;
    localparam int SIG_DESTROY = 5;

    localparam int DEFAULT_BAUD = 9600;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Opposing commands cancel: if both members of a pair are high, neither
    // is sent. Bits 7:6 are always zero.
    function automatic logic [7:0] pack_cmd(
        input logic fwd,
        input logic bwd,
        input logic left,
        input logic right,
        input logic place,
        input logic destroy
    );
        logic [7:0] b;
        b              = '0;
        b[SIG_FWD]     = fwd & ~bwd;
        b[SIG_BWD]     = bwd & ~fwd;
        b[SIG_LEFT]    = left & ~right;
        b[SIG_RIGHT]   = right & ~left;
        b[SIG_PLACE]   = place & ~destroy;
        b[SIG_DESTROY] = destroy & ~place;
        return b;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// ----------------------------------------------------------------------------
// uart_baud_gen
// Bit-period timer. Counts 0..BAUD_DIV-1 and wraps; bit_end marks the final
// cycle of each bit period. restart forces the count back to 0 so a frame
// always begins on a clean bit boundary.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   restart  in   restart the bit period (count <= 0)
//   bit_end  out  high on the last cycle of each bit period
// ----------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int BAUD_DIV = 10417
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_end
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last  = (r_cnt == CW'(BAUD_DIV - 1));
    assign bit_end = w_last;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/car_signal_tx.sv
// ----------------------------------------------------------------------------
// car_signal_tx
// Periodically snapshots the six motion command strobes, cancels conflicting
// pairs, packs them into a byte and sends it as a UART frame (8N1, or 8E1
// when the TX_PARITY_EN macro is defined).
// Ports:
//   clk                     in   system clock (rising edge)
//   rst                     in   synchronous active-high reset
//   turn_left_signal        in   turn-left command
//   turn_right_signal       in   turn-right command
//   move_forward_signal     in   move-forward command
//   move_backward_signal    in   move-backward command
//   place_barrier_signal    in   place-barrier command
//   destroy_barrier_signal  in   destroy-barrier command
//   tx                      out  UART serial line, idles high
//   busy                    out  high from first start-bit cycle to last stop-bit cycle
//   frame_done              out  pulse on the last stop-bit cycle
// ----------------------------------------------------------------------------
module car_signal_tx
    import car_sig_pkg::*;
#(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int BAUD        = DEFAULT_BAUD,
    parameter int SEND_PERIOD = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic turn_left_signal,
    input  logic turn_right_signal,
    input  logic move_forward_signal,
    input  logic move_backward_signal,
    input  logic place_barrier_signal,
    input  logic destroy_barrier_signal,
    output logic tx,
    output logic busy,
    output logic frame_done
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int PW       = (SEND_PERIOD > 1) ? $clog2(SEND_PERIOD) : 1;

    logic [PW-1:0] r_period;
    tx_state_e     r_state;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit_idx;
    logic          r_tx;
    logic          r_busy;
`ifdef TX_PARITY_EN
    logic          r_parity;
`endif

    logic [7:0]    w_byte;
    logic          w_wrap;
    logic          w_snap;
    logic          w_bit_end;

    assign w_byte = pack_cmd(move_forward_signal, move_backward_signal,
                             turn_left_signal, turn_right_signal,
                             place_barrier_signal, destroy_barrier_signal);

    assign w_wrap = (r_period == PW'(SEND_PERIOD - 1));
    // A wrap outside IDLE is simply dropped; no pending-frame flag.
    assign w_snap = w_wrap && (r_state == ST_IDLE);

    // Free-running send-period counter, independent of the FSM.
    always_ff @(posedge clk) begin
        if (rst || w_wrap) begin
            r_period <= '0;
        end else begin
            r_period <= r_period + 1'b1;
        end
    end

    // Restarting on the snapshot cycle aligns the start bit to the frame.
    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (w_snap),
        .bit_end (w_bit_end)
    );

    // tx is registered one state ahead: each transition loads the level of
    // the bit that the new state will drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
`ifdef TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_snap) begin
                        r_shift  <= w_byte;
`ifdef TX_PARITY_EN
                        r_parity <= ^w_byte;
`endif
                        r_tx     <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_tx      <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_idx <= '0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == 3'd7) begin
`ifdef TX_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= ST_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
`ifdef TX_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_tx    <= 1'b1;
                        r_state <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_bit_end) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx         = r_tx;
    assign busy       = r_busy;
    // Decoded from registered state and counter, so it lands exactly on the
    // final stop-bit cycle.
    assign frame_done = (r_state == ST_STOP) && w_bit_end;

endmodule

// File: tb/tb_car_signal_tx.sv
module tb_car_signal_tx;

    localparam int CLK_FREQ    = 100_000_000;
    localparam int BAUD        = 1_000_000;
    localparam int SEND_PERIOD = 2000;
    localparam int BD          = CLK_FREQ / BAUD;
`ifdef TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME    = NBITS * BD;
    localparam int WAIT_MAX = SEND_PERIOD + 500;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic turn_left_signal = 1'b0, turn_right_signal = 1'b0;
    logic move_forward_signal = 1'b0, move_backward_signal = 1'b0;
    logic place_barrier_signal = 1'b0, destroy_barrier_signal = 1'b0;
    logic tx, busy, frame_done;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    car_signal_tx #(
        .CLK_FREQ    (CLK_FREQ),
        .BAUD        (BAUD),
        .SEND_PERIOD (SEND_PERIOD)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .turn_left_signal       (turn_left_signal),
        .turn_right_signal      (turn_right_signal),
        .move_forward_signal    (move_forward_signal),
        .move_backward_signal   (move_backward_signal),
        .place_barrier_signal   (place_barrier_signal),
        .destroy_barrier_signal (destroy_barrier_signal),
        .tx                     (tx),
        .busy                   (busy),
        .frame_done             (frame_done)
    );

    // Observation of one frame as a receiver would see it.
    typedef struct {
        bit         got;
        int         t;
        logic [7:0] data;
        logic       par;
        logic       stop;
        int         start_low;
        logic       tx_after_start;
        bit         busy_ok;
        int         fd_off;
        int         fd_cnt;
        logic       post_tx;
        logic       post_busy;
    } obs_t;

    // Reference: each opposing pair sends its lone active member, or nothing.
    function automatic logic [7:0] ref_byte(input bit f, input bit b, input bit l,
                                            input bit r, input bit p, input bit d);
        int v;
        v = 0;
        if (f != b) v += f ? 1 : 2;
        if (l != r) v += l ? 4 : 8;
        if (p != d) v += p ? 16 : 32;
        return v[7:0];
    endfunction

    task automatic set_sig(input bit f, input bit b, input bit l,
                           input bit r, input bit p, input bit d);
        move_forward_signal    = f;
        move_backward_signal   = b;
        turn_left_signal       = l;
        turn_right_signal      = r;
        place_barrier_signal   = p;
        destroy_barrier_signal = d;
    endtask

    // Waits (bounded) for a start bit, then samples the whole frame at
    // negedges. act_at >= 0 raises turn_right at that frame offset.
    task automatic capture(input int act_at, output obs_t o);
        o = '{default: 0};
        o.fd_off = -1;
        for (int w = 0; w < WAIT_MAX && !o.got; w++) begin
            @(negedge clk);
            if (tx === 1'b0) o.got = 1;
        end
        if (!o.got) return;
        o.t = cyc;
        o.busy_ok = 1;
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) @(negedge clk);
            if (i == act_at) turn_right_signal = 1'b1;
            if (i < BD && tx === 1'b0) o.start_low++;
            if (i == BD) o.tx_after_start = tx;
            for (int k = 0; k < 8; k++)
                if (i == BD * (k + 1) + BD / 2) o.data[k] = tx;
            if (i == BD * 9 + BD / 2) o.par = tx;
            if (i == BD * (NBITS - 1) + BD / 2) o.stop = tx;
            if (busy !== 1'b1) o.busy_ok = 0;
            if (frame_done === 1'b1) begin
                o.fd_cnt++;
                if (o.fd_off < 0) o.fd_off = i;
            end
        end
        @(negedge clk);
        o.post_tx   = tx;
        o.post_busy = busy;
        if (frame_done === 1'b1) o.fd_cnt++;
    endtask

    task automatic test_reset();
        obs_t o;
        int   t_rst;
        logic [7:0] exp;
        set_sig(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
        t_rst = cyc;
        rst = 1'b0;
        exp = ref_byte(0, 0, 0, 0, 0, 0);
        capture(-1, o);
        checks++; if (!o.got) begin failures++; $display("FAIL reset_frame_start got=none exp=frame"); end
        checks++; if (o.t - t_rst !== SEND_PERIOD) begin failures++; $display("FAIL first_start_delay got=%0d exp=%0d", o.t - t_rst, SEND_PERIOD); end
        checks++; if (o.data !== exp) begin failures++; $display("FAIL zero_byte got=%h exp=%h", o.data, exp); end
        checks++; if (o.start_low !== BD) begin failures++; $display("FAIL start_low_cycles got=%0d exp=%0d", o.start_low, BD); end
        checks++; if (o.fd_off !== FRAME - 1) begin failures++; $display("FAIL frame_done_offset got=%0d exp=%0d", o.fd_off, FRAME - 1); end
        checks++; if (o.fd_cnt !== 1) begin failures++; $display("FAIL frame_done_pulses got=%0d exp=1", o.fd_cnt); end
        checks++; if (!o.busy_ok) begin failures++; $display("FAIL busy_in_frame got=low exp=high"); end
        checks++; if (o.post_busy !== 1'b0) begin failures++; $display("FAIL busy_after got=%b exp=0", o.post_busy); end
        checks++; if (o.stop !== 1'b1 || o.post_tx !== 1'b1) begin failures++; $display("FAIL stop_idle got=%b%b exp=11", o.stop, o.post_tx); end
    endtask

    task automatic test_fwd_left();
        obs_t a, b;
        logic [7:0] exp;
        set_sig(1, 0, 1, 0, 0, 0);
        exp = ref_byte(1, 0, 1, 0, 0, 0);
        capture(-1, a);
        capture(-1, b);
        checks++; if (!a.got || !b.got) begin failures++; $display("FAIL fwd_left_start got=%0d%0d exp=11", a.got, b.got); end
        checks++; if (a.data !== exp) begin failures++; $display("FAIL fwd_left_byte0 got=%h exp=%h", a.data, exp); end
        checks++; if (b.data !== exp) begin failures++; $display("FAIL fwd_left_byte1 got=%h exp=%h", b.data, exp); end
        checks++; if (b.t - a.t !== SEND_PERIOD) begin failures++; $display("FAIL frame_period got=%0d exp=%0d", b.t - a.t, SEND_PERIOD); end
        checks++; if (a.tx_after_start !== exp[0]) begin failures++; $display("FAIL start_bit_end got=%b exp=%b", a.tx_after_start, exp[0]); end
        checks++; if (a.start_low !== BD) begin failures++; $display("FAIL fwd_left_start_len got=%0d exp=%0d", a.start_low, BD); end
    endtask

    task automatic test_conflict();
        obs_t o;
        logic [7:0] exp;
        set_sig(1, 1, 0, 0, 1, 0);
        exp = ref_byte(1, 1, 0, 0, 1, 0);
        capture(-1, o);
        checks++; if (o.data !== exp) begin failures++; $display("FAIL conflict_byte got=%h exp=%h", o.data, exp); end
        set_sig(0, 1, 1, 1, 1, 1);
        exp = ref_byte(0, 1, 1, 1, 1, 1);
        capture(-1, o);
        checks++; if (o.data !== exp) begin failures++; $display("FAIL conflict2_byte got=%h exp=%h", o.data, exp); end
    endtask

    task automatic test_midframe();
        obs_t a, b;
        set_sig(0, 0, 0, 0, 0, 0);
        capture(299, a);
        capture(-1, b);
        checks++; if (a.data !== ref_byte(0, 0, 0, 0, 0, 0)) begin failures++; $display("FAIL inflight_byte got=%h exp=00", a.data); end
        checks++; if (b.data !== ref_byte(0, 0, 0, 1, 0, 0)) begin failures++; $display("FAIL next_byte got=%h exp=%h", b.data, ref_byte(0, 0, 0, 1, 0, 0)); end
    endtask

    task automatic test_reset_midframe();
        obs_t o;
        bit   got;
        int   t_rst;
        set_sig(1, 0, 0, 0, 0, 1);
        got = 0;
        for (int w = 0; w < WAIT_MAX && !got; w++) begin
            @(negedge clk);
            if (tx === 1'b0) got = 1;
        end
        checks++; if (!got) begin failures++; $display("FAIL midrst_start got=none exp=frame"); end
        repeat (449) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        t_rst = cyc;
        rst = 1'b0;
        checks++; if (tx !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL midrst_abort got=tx%b busy%b exp=tx1 busy0", tx, busy); end
        capture(-1, o);
        checks++; if (o.t - t_rst !== SEND_PERIOD) begin failures++; $display("FAIL midrst_restart got=%0d exp=%0d", o.t - t_rst, SEND_PERIOD); end
        checks++; if (o.data !== ref_byte(1, 0, 0, 0, 0, 1)) begin failures++; $display("FAIL midrst_byte got=%h exp=%h", o.data, ref_byte(1, 0, 0, 0, 0, 1)); end
    endtask

    task automatic test_random();
        obs_t o;
        int   t_prev;
        bit   s[6];
        logic [7:0] exp;
        t_prev = -1;
        for (int n = 0; n < 8; n++) begin
            for (int j = 0; j < 6; j++) s[j] = 1'($urandom_range(0, 1));
            set_sig(s[0], s[1], s[2], s[3], s[4], s[5]);
            exp = ref_byte(s[0], s[1], s[2], s[3], s[4], s[5]);
            capture(-1, o);
            checks++; if (o.data !== exp) begin failures++; $display("FAIL rand_byte[%0d] got=%h exp=%h", n, o.data, exp); end
            if (t_prev >= 0) begin
                checks++; if (o.t - t_prev !== SEND_PERIOD) begin failures++; $display("FAIL rand_period[%0d] got=%0d exp=%0d", n, o.t - t_prev, SEND_PERIOD); end
            end
            t_prev = o.t;
        end
    endtask

`ifdef TX_PARITY_EN
    task automatic test_parity();
        obs_t o;
        logic [7:0] exp;
        set_sig(1, 0, 1, 0, 0, 0);
        turn_right_signal = 1'b0;
        move_backward_signal = 1'b1;
        move_forward_signal = 1'b0;
        set_sig(0, 1, 1, 0, 0, 0);
        capture(-1, o);
        exp = ref_byte(0, 1, 1, 0, 0, 0);
        checks++; if (o.par !== ^exp) begin failures++; $display("FAIL parity_bit got=%b exp=%b", o.par, ^exp); end
        set_sig(1, 0, 0, 0, 0, 0);
        capture(-1, o);
        exp = ref_byte(1, 0, 0, 0, 0, 0);
        checks++; if (o.par !== ^exp) begin failures++; $display("FAIL parity_bit2 got=%b exp=%b", o.par, ^exp); end
        checks++; if (o.fd_off !== 11 * BD - 1) begin failures++; $display("FAIL parity_fd got=%0d exp=%0d", o.fd_off, 11 * BD - 1); end
    endtask
`endif

    initial begin
        test_reset();
        test_fwd_left();
        test_conflict();
        test_midframe();
        test_reset_midframe();
        test_random();
`ifdef TX_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
